// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared RV32I constants, opcodes and pipeline register types.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } if_id_t;

    // What the fetch stage does on the coming edge.
    typedef enum logic [1:0] {
        FETCH_ADVANCE  = 2'd0,
        FETCH_HOLD     = 2'd1,
        FETCH_REDIRECT = 2'd2,
        FETCH_OOR      = 2'd3
    } fetch_action_e;

    localparam if_id_t IF_ID_RESET = '{
        valid:    1'b0,
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0004,
        instr:    NOP_INSTR
    };

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register with hold and bubble-insert controls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t entry_in,
    output if_id_t entry_out
);

    if_id_t entry_q;
    if_id_t entry_d;

    // A bubble keeps the PC fields so the decoder sees a stable context.
    always_comb begin
        entry_d = entry_q;
        if (bubble) begin
            entry_d.valid = 1'b0;
            entry_d.instr = NOP_INSTR;
        end else if (!hold) begin
            entry_d = entry_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= IF_ID_RESET;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_out = entry_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Brief   : RV32I instruction fetch: PC, next-PC select, fault and counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [32:0] c_imem_bytes = 33'(IMEM_WORDS) * 33'd4;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            fault_q;
    logic            fault_d;
    logic [31:0]     count_q;
    logic [31:0]     count_d;

    fetch_action_e   action;
    logic            pc_in_range;
    logic [XLEN-1:0] pc_plus4;
    logic            id_hold;
    logic            id_bubble;
    if_id_t          id_entry_in;
    if_id_t          id_entry_out;

    assign pc_plus4    = pc_q + 32'd4;
    assign pc_in_range = ({1'b0, pc_q} < c_imem_bytes);

    always_comb begin
        action = FETCH_ADVANCE;
        if (redirect_valid) begin
            action = FETCH_REDIRECT;
        end else if (stall) begin
            action = FETCH_HOLD;
        end else if (!pc_in_range) begin
            action = FETCH_OOR;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        fault_d   = fault_q;
        count_d   = count_q;
        id_hold   = 1'b0;
        id_bubble = 1'b0;
        unique case (action)
            FETCH_REDIRECT: begin
                pc_d      = {redirect_pc[31:2], 2'b00};
                id_bubble = 1'b1;
                if (redirect_pc[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                end
            end
            FETCH_HOLD: begin
                id_hold = 1'b1;
            end
            // PC keeps advancing so trap logic sees a well-defined address.
            FETCH_OOR: begin
                pc_d      = pc_plus4;
                id_bubble = 1'b1;
                fault_d   = 1'b1;
            end
            default: begin
                pc_d    = pc_plus4;
                count_d = count_q + 32'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign id_entry_in = '{
        valid:    1'b1,
        pc:       pc_q,
        pc_plus4: pc_plus4,
        instr:    imem_rdata
    };

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .hold      (id_hold),
        .bubble    (id_bubble),
        .entry_in  (id_entry_in),
        .entry_out (id_entry_out)
    );

    assign imem_addr      = pc_q;
    assign if_id_valid    = id_entry_out.valid;
    assign if_id_pc       = id_entry_out.pc;
    assign if_id_pc_plus4 = id_entry_out.pc_plus4;
    assign if_id_instr    = id_entry_out.instr;
    assign fetch_fault    = fault_q;
    assign fetch_count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Brief   : Self-checking bench for if_stage against a behavioural fetch model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam int          WORDS  = 128;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] I_ADDI = 32'h002A_8B13;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [WORDS];

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the spec says the stage holds after each edge.
    logic [31:0] m_pc, m_id_pc, m_p4, m_instr, m_cnt;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    // Out-of-range reads return junk so a bubble can't be confused with data.
    assign imem_rdata = (imem_addr < 32'(WORDS * 4)) ? mem[imem_addr[8:2]]
                                                     : (imem_addr ^ 32'hDEAD_BEEF);

    if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    task automatic model_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_p4 = 32'h4; m_instr = NOP;
        m_cnt = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        #7;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock with the given controls; the model advances by the spec rules.
    task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        stall = s; redirect_valid = rv; redirect_pc = rpc;
        if (rv) begin
            if (rpc % 4 != 0) m_fault = 1'b1;
            m_pc    = rpc - (rpc % 4);
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (!s) begin
            if (m_pc < WORDS * 4) begin
                m_valid = 1'b1;
                m_id_pc = m_pc;
                m_p4    = m_pc + 32'd4;
                m_instr = mem[m_pc / 4];
                m_cnt   = m_cnt + 32'd1;
            end else begin
                m_valid = 1'b0;
                m_instr = NOP;
                m_fault = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'h0031_00B3;
        mem[1]  = 32'h4062_8233;
        mem[2]  = 32'h0094_73B3;
        mem[3]  = 32'h00C5_E533;
        mem[4]  = 32'h00F7_46B3;
        mem[10] = I_ADDI;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
            if_id_pc_plus4 !== 32'h4 || if_id_instr !== NOP ||
            fetch_fault !== 1'b0 || fetch_count !== 32'h0) begin
            n_err++;
            $display("FAIL reset_values: got addr=%h v=%b pc=%h p4=%h ins=%h flt=%b cnt=%0d, want 0/0/0/4/%h/0/0",
                     imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
                     fetch_fault, fetch_count, NOP);
        end
        #6;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(i * 4) ||
                if_id_pc_plus4 !== 32'(i * 4 + 4) || if_id_instr !== mem[i]) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: got v=%b pc=%h p4=%h ins=%h, want 1 %h %h %h",
                         i, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
                         32'(i * 4), 32'(i * 4 + 4), mem[i]);
            end
        end
        n_cmp++;
        if (fetch_count !== 32'd5 || fetch_fault !== 1'b0) begin
            n_err++;
            $display("FAIL seq_count: got cnt=%0d flt=%b, want 5 0", fetch_count, fetch_fault);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (if_id_pc !== 32'h8 || imem_addr !== 32'hC || fetch_count !== 32'd3 ||
                if_id_instr !== mem[2]) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got pc=%h addr=%h cnt=%0d ins=%h, want 8 c 3 %h",
                         i, if_id_pc, imem_addr, fetch_count, if_id_instr, mem[2]);
            end
        end
        step(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_pc !== 32'hC || if_id_valid !== 1'b1 || if_id_instr !== mem[3]) begin
            n_err++;
            $display("FAIL stall_release: got pc=%h v=%b ins=%h, want c 1 %h",
                     if_id_pc, if_id_valid, if_id_instr, mem[3]);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h28);
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== 32'h28 ||
            fetch_count !== 32'd4) begin
            n_err++;
            $display("FAIL redirect_bubble: got v=%b ins=%h addr=%h cnt=%0d, want 0 %h 28 4",
                     if_id_valid, if_id_instr, imem_addr, fetch_count, NOP);
        end
        step(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h28 || if_id_instr !== I_ADDI) begin
            n_err++;
            $display("FAIL redirect_target: got v=%b pc=%h ins=%h, want 1 28 %h",
                     if_id_valid, if_id_pc, if_id_instr, I_ADDI);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40);
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== 32'h40 ||
            if_id_pc !== 32'h4 || fetch_count !== 32'd2) begin
            n_err++;
            $display("FAIL redirect_over_stall: got v=%b ins=%h addr=%h pc=%h cnt=%0d, want 0 nop 40 4 2",
                     if_id_valid, if_id_instr, imem_addr, if_id_pc, fetch_count);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        step(1'b0, 1'b1, 32'h2E);
        n_cmp++;
        if (imem_addr !== 32'h2C || fetch_fault !== 1'b1) begin
            n_err++;
            $display("FAIL misaligned: got addr=%h flt=%b, want 2c 1", imem_addr, fetch_fault);
        end
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0, 32'h0);
        n_cmp++;
        if (fetch_fault !== 1'b1) begin
            n_err++;
            $display("FAIL fault_sticky: got flt=%b, want 1", fetch_fault);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        step(1'b0, 1'b1, 32'h1F8);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h1FC || fetch_fault !== 1'b0 ||
            fetch_count !== 32'd2) begin
            n_err++;
            $display("FAIL last_word: got v=%b pc=%h flt=%b cnt=%0d, want 1 1fc 0 2",
                     if_id_valid, if_id_pc, fetch_fault, fetch_count);
        end
        step(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || fetch_fault !== 1'b1 ||
            fetch_count !== 32'd2 || imem_addr !== 32'h204) begin
            n_err++;
            $display("FAIL oor_bubble: got v=%b ins=%h flt=%b cnt=%0d addr=%h, want 0 nop 1 2 204",
                     if_id_valid, if_id_instr, fetch_fault, fetch_count, imem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
            if_id_pc_plus4 !== 32'h4 || if_id_instr !== NOP ||
            fetch_fault !== 1'b0 || fetch_count !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got addr=%h v=%b pc=%h p4=%h ins=%h flt=%b cnt=%0d, want reset values",
                     imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
                     fetch_fault, fetch_count);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_pc_wrap();
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || fetch_fault !== 1'b1) begin
            n_err++;
            $display("FAIL pc_wrap: got addr=%h v=%b flt=%b, want 0 0 1",
                     imem_addr, if_id_valid, fetch_fault);
        end
        step(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== mem[0]) begin
            n_err++;
            $display("FAIL wrap_refetch: got v=%b pc=%h ins=%h, want 1 0 %h",
                     if_id_valid, if_id_pc, if_id_instr, mem[0]);
        end
    endtask

    task automatic test_random();
        logic        s, rv;
        logic [31:0] rpc;
        int          sel;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0)      rpc = $urandom;
            else if (sel == 1) rpc = 32'($urandom_range(0, WORDS * 4 - 1));
            else               rpc = 32'($urandom_range(0, WORDS - 1) * 4);
            if (i == 200) begin
                do_reset();
            end
            step(s, rv, rpc);
            n_cmp++;
            if (imem_addr !== m_pc || if_id_valid !== m_valid || if_id_pc !== m_id_pc ||
                if_id_pc_plus4 !== m_p4 || if_id_instr !== m_instr ||
                fetch_fault !== m_fault || fetch_count !== m_cnt) begin
                n_err++;
                $display("FAIL random[%0d]: got addr=%h v=%b pc=%h p4=%h ins=%h flt=%b cnt=%0d, want %h %b %h %h %h %b %0d",
                         i, imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
                         fetch_fault, fetch_count, m_pc, m_valid, m_id_pc, m_p4, m_instr,
                         m_fault, m_cnt);
            end
        end
    endtask

    initial begin
        load_program();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misaligned();
        test_out_of_range();
        test_pc_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
